// File: rtl/aeses_pkg.sv
// Shared definitions for the AESES UART command controller: key mode codes,
// control-byte field positions, controller state encoding and frame sizes.
package aeses_pkg;

   localparam int KEY_BYTES = 32;
   localparam int BLK_BYTES = 16;

   localparam logic [1:0] KEY_128 = 2'b00;
   localparam logic [1:0] KEY_192 = 2'b01;
   localparam logic [1:0] KEY_256 = 2'b10;

   localparam int CTRL_K_BIT   = 7;
   localparam int CTRL_MODE_HI = 6;
   localparam int CTRL_MODE_LO = 5;
   localparam int CTRL_G_BIT   = 4;
   localparam int CTRL_E_BIT   = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_KEY_RX    = 3'd1,
      ST_KEY_START = 3'd2,
      ST_KEY_WAIT  = 3'd3,
      ST_DATA_RX   = 3'd4,
      ST_OP_START  = 3'd5,
      ST_OP_WAIT   = 3'd6,
      ST_TX_SEND   = 3'd7
   } state_t;

   function automatic logic mode_ok(input logic [1:0] m);
      return (m == KEY_128) || (m == KEY_192) || (m == KEY_256);
   endfunction

   // Key frame: K set, G/E/reserved clear, legal mode.
   function automatic logic ctrl_is_key(input logic [7:0] b);
      return b[CTRL_K_BIT] && (b[4:0] == 5'd0) && mode_ok(b[CTRL_MODE_HI:CTRL_MODE_LO]);
   endfunction

   // Op frame: K clear, G set, reserved clear, legal mode.
   function automatic logic ctrl_is_op(input logic [7:0] b);
      return !b[CTRL_K_BIT] && b[CTRL_G_BIT] && (b[2:0] == 3'd0) &&
             mode_ok(b[CTRL_MODE_HI:CTRL_MODE_LO]);
   endfunction

endpackage

// File: rtl/aeses_byte_serializer.sv
// Loads a 128-bit word and emits it MSB byte first over a valid/ready byte
// interface; o_last flags the cycle in which the 16th byte is accepted.
module aeses_byte_serializer (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [127:0] i_data,
   input  logic         i_ready,
   output logic [7:0]   o_data,
   output logic         o_valid,
   output logic         o_last
);

   logic [127:0] r_shift;
   logic [3:0]   r_cnt;
   logic         r_valid;

   // Capture the word on load, then shift one byte out per accepted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= 128'd0;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_cnt   <= 4'd0;
         r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
         r_shift <= {r_shift[119:0], 8'h00};
         r_cnt   <= r_cnt + 4'd1;
         if (r_cnt == 4'd15) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data  = r_shift[127:120];
   assign o_valid = r_valid;
   assign o_last  = r_valid && i_ready && (r_cnt == 4'd15);

endmodule

// File: rtl/aeses_uart_cmd_ctrl.sv
// Command/framing controller between the UART byte stream and the AESES core:
// decodes control bytes, assembles keys and blocks, launches the core and
// returns the 16-byte result through aeses_byte_serializer.
// Optional inter-byte timeout: define AESES_RX_TIMEOUT_EN.
module aeses_uart_cmd_ctrl
   import aeses_pkg::*;
#(
   parameter int KEY_BYTES      = aeses_pkg::KEY_BYTES,
   parameter int BLK_BYTES      = aeses_pkg::BLK_BYTES,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [255:0] key_o,
   output logic [1:0]   key_mode_o,
   output logic         key_start_o,
   input  logic         key_done_i,
   output logic [127:0] blk_o,
   output logic         enc_o,
   output logic         op_start_o,
   input  logic         res_valid_i,
   input  logic [127:0] res_i,
   output logic         key_loaded_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam logic [5:0] KEY_LAST = 6'(KEY_BYTES - 1);
   localparam logic [5:0] BLK_LAST = 6'(BLK_BYTES - 1);

   state_t         r_state;
   logic [5:0]     r_cnt;
   logic [255:0]   r_key;
   logic [127:0]   r_blk;
   logic [1:0]     r_key_mode;
   logic [1:0]     r_op_mode;
   logic           r_enc;
   logic           r_key_start;
   logic           r_op_start;
   logic           r_key_loaded;
   logic           r_err;
   logic           w_ser_load;
   logic           w_ser_last;
   logic           w_in_frame;
   logic           w_timeout;

   assign w_in_frame = (r_state == ST_KEY_RX) || (r_state == ST_DATA_RX);
   assign w_ser_load = (r_state == ST_OP_WAIT) && res_valid_i;

`ifdef AESES_RX_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] r_gap;

   assign w_timeout = w_in_frame && !rx_valid && (r_gap == TIMEOUT_LAST);

   // Inter-byte gap counter: restarts on every byte and whenever no frame is open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gap <= 32'd0;
      end else if (w_in_frame && !rx_valid && !w_timeout) begin
         r_gap <= r_gap + 32'd1;
      end else begin
         r_gap <= 32'd0;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 32'sd0);
   assign w_timeout        = 1'b0;
`endif

   // Frame sequencing FSM with registered start/error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 6'd0;
         r_key        <= 256'd0;
         r_blk        <= 128'd0;
         r_key_mode   <= 2'b00;
         r_op_mode    <= 2'b00;
         r_enc        <= 1'b0;
         r_key_start  <= 1'b0;
         r_op_start   <= 1'b0;
         r_key_loaded <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_key_start <= 1'b0;
         r_op_start  <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rx_valid) begin
                  if (ctrl_is_key(rx_data)) begin
                     r_key_mode <= rx_data[CTRL_MODE_HI:CTRL_MODE_LO];
                     r_cnt      <= 6'd0;
                     r_state    <= ST_KEY_RX;
                  end else if (ctrl_is_op(rx_data)) begin
                     r_op_mode <= rx_data[CTRL_MODE_HI:CTRL_MODE_LO];
                     r_enc     <= rx_data[CTRL_E_BIT];
                     r_cnt     <= 6'd0;
                     r_state   <= ST_DATA_RX;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_KEY_RX: begin
               if (rx_valid) begin
                  r_key <= {r_key[247:0], rx_data};
                  if (r_cnt == KEY_LAST) begin
                     r_cnt        <= 6'd0;
                     r_key_start  <= 1'b1;
                     r_key_loaded <= 1'b0;
                     r_state      <= ST_KEY_START;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end else if (w_timeout) begin
                  r_cnt   <= 6'd0;
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_KEY_START: begin
               r_err   <= rx_valid;
               r_state <= ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
               r_err <= rx_valid;
               if (key_done_i) begin
                  r_key_loaded <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            ST_DATA_RX: begin
               if (rx_valid) begin
                  r_blk <= {r_blk[119:0], rx_data};
                  if (r_cnt == BLK_LAST) begin
                     r_cnt <= 6'd0;
                     // Block is always consumed; only a matching loaded key launches it.
                     if (r_key_loaded && (r_op_mode == r_key_mode)) begin
                        r_op_start <= 1'b1;
                        r_state    <= ST_OP_START;
                     end else begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end else if (w_timeout) begin
                  r_cnt   <= 6'd0;
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_OP_START: begin
               r_err   <= rx_valid;
               r_state <= ST_OP_WAIT;
            end
            ST_OP_WAIT: begin
               r_err <= rx_valid;
               if (res_valid_i) begin
                  r_state <= ST_TX_SEND;
               end
            end
            ST_TX_SEND: begin
               r_err <= rx_valid;
               if (w_ser_last) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   aeses_byte_serializer u_ser (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_ser_load),
      .i_data  (res_i),
      .i_ready (tx_ready),
      .o_data  (tx_data),
      .o_valid (tx_valid),
      .o_last  (w_ser_last)
   );

   assign key_o        = r_key;
   assign key_mode_o   = r_key_mode;
   assign key_start_o  = r_key_start;
   assign blk_o        = r_blk;
   assign enc_o        = r_enc;
   assign op_start_o   = r_op_start;
   assign key_loaded_o = r_key_loaded;
   assign busy_o       = (r_state != ST_IDLE);
   assign err_o        = r_err;

endmodule

// File: tb/tb_aeses_uart_cmd_ctrl.sv
// Self-checking bench for aeses_uart_cmd_ctrl: directed test-plan vectors plus
// randomized frames scored against a frame-level reference model.
module tb_aeses_uart_cmd_ctrl;

   logic         clk;
   logic         rst;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic [255:0] key_o;
   logic [1:0]   key_mode_o;
   logic         key_start_o;
   logic         key_done_i;
   logic [127:0] blk_o;
   logic         enc_o;
   logic         op_start_o;
   logic         res_valid_i;
   logic [127:0] core_res;
   logic         key_loaded_o;
   logic         busy_o;
   logic         err_o;

   int checks = 0;
   int failures = 0;
   int n_kstart = 0;
   int n_ostart = 0;
   int n_err = 0;
   int txr_mode = 0;
   int key_cd = 0;
   int op_cd = 0;
   bit res_seen = 1'b0;
   bit m_loaded = 1'b0;
   logic [1:0] m_mode = 2'b00;
   logic [7:0] fb [0:31];
   logic [7:0] tx_q [$];

   aeses_uart_cmd_ctrl dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .key_o(key_o), .key_mode_o(key_mode_o), .key_start_o(key_start_o),
      .key_done_i(key_done_i), .blk_o(blk_o), .enc_o(enc_o),
      .op_start_o(op_start_o), .res_valid_i(res_valid_i), .res_i(core_res),
      .key_loaded_o(key_loaded_o), .busy_o(busy_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Core model and TX sink: respond to start pulses after 3 cycles, drive tx_ready.
   always @(posedge clk) begin
      #1;
      key_done_i  = 1'b0;
      res_valid_i = 1'b0;
      if (rst) begin
         key_cd = 0;
         op_cd  = 0;
      end else begin
         if (key_cd != 0) begin
            key_cd--;
            if (key_cd == 0) key_done_i = 1'b1;
         end
         if (op_cd != 0) begin
            op_cd--;
            if (op_cd == 0) res_valid_i = 1'b1;
         end
         if (key_start_o) key_cd = 3;
         if (op_start_o) op_cd = 3;
      end
      case (txr_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = ~tx_ready;
         default: tx_ready = 1'b0;
      endcase
   end

   // Monitor: count pulses, collect transferred bytes, check result-to-TX latency.
   always @(negedge clk) begin
      if (res_seen) chk("res_to_tx_valid", tx_valid, 1'b1);
      res_seen = res_valid_i;
      if (key_start_o) n_kstart++;
      if (op_start_o) n_ostart++;
      if (err_o) n_err++;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
   end

   task automatic send_frame(input logic [7:0] ctrl, input int n, input int maxgap);
      int g;
      @(posedge clk); #1; rx_data = ctrl; rx_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         g = $urandom_range(maxgap, 0);
         repeat (g) begin @(posedge clk); #1; rx_valid = 1'b0; end
         @(posedge clk); #1; rx_data = fb[i]; rx_valid = 1'b1;
      end
      @(posedge clk); #1; rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (!busy_o) done = 1'b1;
      end
      chk(tag, done, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_key(input logic [1:0] mode, input logic [255:0] key, input int maxgap);
      int k0, e0;
      k0 = n_kstart; e0 = n_err;
      for (int i = 0; i < 32; i++) fb[i] = key[255-8*i -: 8];
      send_frame({1'b1, mode, 5'b00000}, 32, maxgap);
      chk("key_start_latency", key_start_o, 1'b1);
      chk("key_loaded_drop", key_loaded_o, 1'b0);
      wait_idle("key_done_timeout");
      chk("key_o", key_o, key);
      chk("key_mode_o", key_mode_o, mode);
      chk("key_loaded_o", key_loaded_o, 1'b1);
      chk("key_start_count", n_kstart - k0, 1);
      chk("key_err_count", n_err - e0, 0);
      m_loaded = 1'b1;
      m_mode   = mode;
   endtask

   task automatic do_op(input logic [1:0] mode, input logic enc, input logic [127:0] blk,
                        input logic [127:0] res, input int maxgap);
      int o0, e0, exp_n;
      bit ok;
      o0 = n_ostart; e0 = n_err;
      ok = m_loaded && (mode == m_mode);
      exp_n = ok ? 16 : 0;
      core_res = res;
      for (int i = 0; i < 16; i++) fb[i] = blk[127-8*i -: 8];
      send_frame({1'b0, mode, 1'b1, enc, 3'b000}, 16, maxgap);
      chk("op_start_now", op_start_o, ok);
      wait_idle("op_done_timeout");
      chk("blk_o", blk_o, blk);
      chk("enc_o", enc_o, enc);
      chk("op_start_count", n_ostart - o0, ok ? 1 : 0);
      chk("op_err_count", n_err - e0, ok ? 0 : 1);
      chk("tx_count", tx_q.size(), exp_n);
      for (int i = 0; i < tx_q.size() && i < exp_n; i++) chk("tx_byte", tx_q[i], res[127-8*i -: 8]);
      tx_q.delete();
   endtask

   task automatic bad_ctrl(input logic [7:0] b);
      int k0, o0;
      k0 = n_kstart; o0 = n_ostart;
      send_frame(b, 0, 0);
      chk("bad_ctrl_err", err_o, 1'b1);
      chk("bad_ctrl_idle", busy_o, 1'b0);
      repeat (3) @(negedge clk);
      chk("bad_ctrl_no_start", (n_kstart - k0) + (n_ostart - o0), 0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      m_loaded = 1'b0;
      tx_q.delete();
   endtask

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [255:0] k;
      logic [127:0] b, r;
      logic [1:0]   md;
      bit           seen;
      rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; core_res = 128'd0;
      key_done_i = 1'b0; res_valid_i = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_key_o", key_o, 256'd0);
      chk("rst_blk_o", blk_o, 128'd0);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_outs", {tx_data, key_mode_o, key_start_o, enc_o, op_start_o, key_loaded_o, busy_o, err_o}, 16'd0);
      release_reset();

      // Op before any key: block consumed, error, no response
      do_op(2'b00, 1'b0, rnd128(), rnd128(), 0);

      // 128-bit key frame
      do_key(2'b00, 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000, 0);

      // 192-bit key frame then known encrypt vector
      do_key(2'b01, 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000, 0);
      do_op(2'b01, 1'b1, 128'h00112233445566778899aabbccddeeff,
            128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0);

      // Mode mismatch against the loaded key
      do_op(2'b00, 1'b0, rnd128(), rnd128(), 0);

      // Illegal control bytes
      bad_ctrl(8'h60);
      bad_ctrl(8'h81);
      bad_ctrl(8'h00);

      // Three op frames with tx_ready toggling every cycle
      txr_mode = 1;
      b = rnd128(); r = rnd128();
      for (int i = 0; i < 3; i++) do_op(2'b01, 1'b0, b, r, 0);
      txr_mode = 0;

      // Randomized frames with random inter-byte gaps
      for (int it = 0; it < 12; it++) begin
         txr_mode = $urandom_range(1, 0);
         md = 2'($urandom_range(2, 0));
         if ($urandom_range(2, 0) == 0) begin
            do_key(md, rnd256(), 2);
         end else begin
            if ($urandom_range(3, 0) != 0) md = m_mode;
            do_op(md, 1'($urandom_range(1, 0)), rnd128(), rnd128(), 2);
         end
      end

      // Reset in the middle of a result transfer
      txr_mode = 2;
      if (!m_loaded) do_key(2'b10, rnd256(), 0);
      core_res = rnd128();
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      send_frame({1'b0, m_mode, 1'b1, 1'b1, 3'b000}, 16, 0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (tx_valid) seen = 1'b1;
      end
      chk("tx_valid_before_reset", seen, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_mid_tx_valid", tx_valid, 1'b0);
      chk("rst_mid_tx_state", {busy_o, key_loaded_o, tx_data}, 10'd0);
      release_reset();
      txr_mode = 0;

      // Reset after 10 key bytes, then a fresh key and op
      for (int i = 0; i < 32; i++) fb[i] = 8'($urandom_range(255, 1));
      send_frame(8'hC0, 10, 0);
      chk("partial_key_busy", busy_o, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_mid_key_o", key_o, 256'd0);
      chk("rst_mid_key_busy", busy_o, 1'b0);
      release_reset();
      k = rnd256();
      do_key(2'b10, k, 1);
      do_op(2'b10, 1'b0, rnd128(), rnd128(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
